master_req_queue: RTL and testbench
===================================

MASTER_REQ_QUEUE -- requirements
Module: master_req_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of write and read data.
REQ-002 Parameter ADDR_WIDTH, default 16, SHALL set the width of the transaction address.
REQ-003 Parameter DEPTH, default 4, SHALL set the number of queue entries; the only legal value is 4, so the pointers are 2 bits wide.
REQ-004 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be the reset, asynchronous and active-high.
REQ-006 in_valid  input  1  SHALL mean the host offers a transaction.
REQ-007 in_ready  output  1  SHALL mean the queue accepts the transaction this cycle.
REQ-008 in_cmd  input  1  SHALL give the operation: 0 = read, 1 = write.
REQ-009 in_addr  input  ADDR_WIDTH  SHALL give the transaction address.
REQ-010 in_wdata  input  DATA_WIDTH  SHALL give the write data.
REQ-011 req_m  output  1  SHALL be the request to the crossbar master port.
REQ-012 cmd_m  output  1  SHALL be the operation of the issued transaction.
REQ-013 addr_m  output  ADDR_WIDTH  SHALL be the address of the issued transaction.
REQ-014 wdata_m  output  DATA_WIDTH  SHALL be the write data of the issued transaction.
REQ-015 ack_m  input  1  SHALL be the acknowledge from the selected slave (ack_1s OR ack_2s).
REQ-016 rdata_m  input  DATA_WIDTH  SHALL be the read data from the selected slave, valid with ack_m.
REQ-017 resp_valid  output  1  SHALL be a one-cycle pulse marking a completed transaction.
REQ-018 resp_cmd  output  1  SHALL give the operation of the completed transaction.
REQ-019 resp_rdata  output  DATA_WIDTH  SHALL give the captured read data, or 0 for a write.
REQ-020 count  output  3  SHALL give the number of occupied entries, 0..4.

Function
REQ-021 The block SHALL store {cmd, addr, wdata} in a 4-entry FIFO with 2-bit write and read pointers that wrap from 3 to 0.
REQ-022 in_ready SHALL equal (count != 4), decoded from registered count only.
REQ-023 A push SHALL occur on a rising edge where in_valid && in_ready; count increments on the following edge unless a pop occurs on the same edge.
REQ-024 The issue FSM SHALL have three states: IDLE, REQ and RESP.
REQ-025 IDLE -> REQ SHALL occur when count != 0; on entry, req_m, cmd_m, addr_m and wdata_m are loaded from the head entry.
REQ-026 The earliest req_m assertion SHALL be one cycle after the push edge into an empty queue.
REQ-027 In REQ, req_m SHALL stay 1 and cmd_m, addr_m, wdata_m SHALL stay stable until ack_m = 1 is sampled.
REQ-028 REQ -> RESP on ack_m SHALL, on that edge: pop the head, capture rdata_m (if cmd_m = 0) into resp_rdata, and drive req_m to 0.
REQ-029 In RESP, resp_valid SHALL be 1 for exactly one cycle.
REQ-030 RESP -> REQ SHALL occur if count != 0, loading the new head; otherwise RESP -> IDLE.
REQ-031 Minimum spacing between successive req_m rising edges SHALL therefore be 2 cycles after each ack.
REQ-032 ack_m sampled in IDLE or RESP SHALL be ignored, with no pop and no state change.
REQ-033 A push and a pop on the same edge SHALL leave count unchanged and advance both pointers.
REQ-034 When count = 4, in_valid SHALL be ignored even if a pop occurs on that edge.
REQ-035 A write response SHALL drive resp_rdata to 0.
REQ-036 resp_cmd SHALL equal the cmd of the popped entry.
REQ-037 All outputs SHALL be registered except in_ready, which is a compare on registered count.

Reset
REQ-038 reset = 1 SHALL immediately, without waiting for a clock edge, force: state IDLE, pointers 0, count 0, req_m 0, cmd_m 0, addr_m 0, wdata_m 0, resp_valid 0, resp_cmd 0, resp_rdata 0.
REQ-039 With reset = 1, in_ready SHALL be 1.
REQ-040 Reset asserted while in REQ SHALL drop req_m in the same cycle and discard all queued entries.
REQ-041 No response SHALL be generated for a transaction discarded by reset.
REQ-042 After reset deassertion, the first push SHALL be accepted on the next rising edge.

Verification
REQ-043 Single read: push cmd=0, addr=0x0010 into an empty queue -> req_m = 1 next cycle with addr_m = 0x0010; ack_m = 1 with rdata_m = 0xDEADBEEF -> one cycle later resp_valid = 1, resp_cmd = 0, resp_rdata = 0xDEADBEEF, count = 0.
REQ-044 Fill: push 5 writes back-to-back with ack_m held 0 -> first 4 accepted, count = 4, in_ready = 0, 5th held off; one ack -> in_ready = 1 after the pop.
REQ-045 Order and wrap: push 6 writes (addr 1..6) while acking each request -> addr_m sequence 1..6 with correct pointer wrap, six resp_valid pulses, each resp_rdata = 0.
REQ-046 Spurious ack: pulse ack_m in IDLE with count = 0 -> no resp_valid, count stays 0.
REQ-047 Simultaneous push/pop: at count = 2, push on the same edge as ack_m -> count stays 2, next addr_m is the older entry.
REQ-048 Reset mid-request: assert reset while req_m = 1 and count = 3 -> req_m = 0 before the next edge, count = 0, no resp_valid after release.

Source files
------------

// File: rtl/master_req_queue.sv
// Four-entry request FIFO that issues one transaction at a time to a crossbar master port
// and returns a single-cycle response pulse per completed transaction.
module master_req_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_cmd,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0] in_wdata,
   output logic                  req_m,
   output logic                  cmd_m,
   output logic [ADDR_WIDTH-1:0] addr_m,
   output logic [DATA_WIDTH-1:0] wdata_m,
   input  logic                  ack_m,
   input  logic [DATA_WIDTH-1:0] rdata_m,
   output logic                  resp_valid,
   output logic                  resp_cmd,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic [2:0]            count
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic [1:0]            r_wrPtr;
   logic [1:0]            r_rdPtr;
   logic [2:0]            r_count;
   logic                  r_memCmd  [DEPTH];
   logic [ADDR_WIDTH-1:0] r_memAddr [DEPTH];
   logic [DATA_WIDTH-1:0] r_memWdata[DEPTH];
   logic                  r_reqM;
   logic                  r_cmdM;
   logic [ADDR_WIDTH-1:0] r_addrM;
   logic [DATA_WIDTH-1:0] r_wdataM;
   logic                  r_respValid;
   logic                  r_respCmd;
   logic [DATA_WIDTH-1:0] r_respRdata;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_load;

   assign in_ready = (r_count != 3'd4);
   assign w_push   = in_valid && in_ready;
   assign w_pop    = (r_state == REQ) && ack_m;
   // A new head is presented whenever we leave IDLE or RESP with entries waiting.
   assign w_load   = (w_nextState == REQ) && (r_state != REQ);

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (r_count != 3'd0) w_nextState = REQ;
         REQ:     if (ack_m) w_nextState = RESP;
         RESP:    w_nextState = (r_count != 3'd0) ? REQ : IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_wrPtr <= 2'd0;
         r_rdPtr <= 2'd0;
         r_count <= 3'd0;
      end else begin
         r_state <= w_nextState;
         if (w_push) r_wrPtr <= r_wrPtr + 2'd1;
         if (w_pop)  r_rdPtr <= r_rdPtr + 2'd1;
         r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_memCmd[r_wrPtr]   <= in_cmd;
         r_memAddr[r_wrPtr]  <= in_addr;
         r_memWdata[r_wrPtr] <= in_wdata;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_reqM      <= 1'b0;
         r_cmdM      <= 1'b0;
         r_addrM     <= '0;
         r_wdataM    <= '0;
         r_respValid <= 1'b0;
         r_respCmd   <= 1'b0;
         r_respRdata <= '0;
      end else begin
         r_respValid <= w_pop;
         if (w_load) begin
            r_reqM   <= 1'b1;
            r_cmdM   <= r_memCmd[r_rdPtr];
            r_addrM  <= r_memAddr[r_rdPtr];
            r_wdataM <= r_memWdata[r_rdPtr];
         end else if (w_pop) begin
            r_reqM <= 1'b0;
         end
         // Writes report zero data so the host never sees a stale read value.
         if (w_pop) begin
            r_respCmd   <= r_cmdM;
            r_respRdata <= r_cmdM ? '0 : rdata_m;
         end
      end
   end

   assign req_m      = r_reqM;
   assign cmd_m      = r_cmdM;
   assign addr_m     = r_addrM;
   assign wdata_m    = r_wdataM;
   assign resp_valid = r_respValid;
   assign resp_cmd   = r_respCmd;
   assign resp_rdata = r_respRdata;
   assign count      = r_count;

endmodule

// File: tb/tb_master_req_queue.sv
// Bench for master_req_queue: a queue-based transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_master_req_queue;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        in_cmd;
   logic [15:0] in_addr;
   logic [31:0] in_wdata;
   logic        req_m;
   logic        cmd_m;
   logic [15:0] addr_m;
   logic [31:0] wdata_m;
   logic        ack_m;
   logic [31:0] rdata_m;
   logic        resp_valid;
   logic        resp_cmd;
   logic [31:0] resp_rdata;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   master_req_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(4)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
      .in_addr(in_addr), .in_wdata(in_wdata),
      .req_m(req_m), .cmd_m(cmd_m), .addr_m(addr_m), .wdata_m(wdata_m),
      .ack_m(ack_m), .rdata_m(rdata_m),
      .resp_valid(resp_valid), .resp_cmd(resp_cmd), .resp_rdata(resp_rdata),
      .count(count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        cmd;
      logic [15:0] addr;
      logic [31:0] wdata;
   } entry_t;

   // Model: pending transactions as a plain queue; the head is what the host sees issued.
   entry_t      mq[$];
   bit          mReq;
   bit          mResp;
   logic        mRespCmd;
   logic [31:0] mRespRdata;
   bit          mPush;
   int          mSize;

   // Observation log for the directed scenarios.
   logic [15:0] addrLog[$];
   int          respPulses;
   int          nonzeroWriteResp;

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // Transaction-level model advanced on each edge from the pre-edge inputs.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mq.delete();
         mReq       = 1'b0;
         mResp      = 1'b0;
         mRespCmd   = 1'b0;
         mRespRdata = '0;
      end else begin
         mSize = mq.size();
         mPush = in_valid && (mSize != 4);
         if (mReq && ack_m) begin
            mRespCmd   = mq[0].cmd;
            mRespRdata = mq[0].cmd ? 32'd0 : rdata_m;
            void'(mq.pop_front());
            mReq  = 1'b0;
            mResp = 1'b1;
         end else if (!mReq) begin
            mResp = 1'b0;
            if (mSize != 0) mReq = 1'b1;
         end
         if (mPush) mq.push_back('{cmd: in_cmd, addr: in_addr, wdata: in_wdata});
      end
   end

   // Compare every cycle on the falling edge, away from the active edge.
   always @(negedge clock) begin
      checkVal("count", count, mq.size());
      checkVal("in_ready", in_ready, mq.size() != 4);
      checkVal("req_m", req_m, mReq);
      checkVal("resp_valid", resp_valid, mResp);
      if (mReq && mq.size() != 0) begin
         checkVal("cmd_m", cmd_m, mq[0].cmd);
         checkVal("addr_m", addr_m, mq[0].addr);
         checkVal("wdata_m", wdata_m, mq[0].wdata);
      end
      if (mResp) begin
         checkVal("resp_cmd", resp_cmd, mRespCmd);
         checkVal("resp_rdata", resp_rdata, mRespRdata);
      end
      if (req_m && ack_m) addrLog.push_back(addr_m);
      if (resp_valid) begin
         respPulses++;
         if (resp_cmd && resp_rdata != 0) nonzeroWriteResp++;
      end
   end

   task automatic applyStimulus(input logic v, input logic c, input logic [15:0] a,
                                input logic [31:0] d, input logic ack, input logic [31:0] rd);
      in_valid = v;
      in_cmd   = c;
      in_addr  = a;
      in_wdata = d;
      ack_m    = ack;
      rdata_m  = rd;
   endtask

   task automatic pushOne(input logic c, input logic [15:0] a, input logic [31:0] d);
      bit acc;
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_cmd   = c;
      in_addr  = a;
      in_wdata = d;
      do begin
         acc = (mq.size() != 4);
         tick();
         guard++;
      end while (!acc && guard < 50);
      checkVal("push_timeout", acc, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard    = 0;
      in_valid = 1'b0;
      ack_m    = 1'b1;
      while ((mq.size() != 0 || mReq || mResp) && guard < 200) begin
         rdata_m = $urandom;
         tick();
         guard++;
      end
      checkVal("drain_timeout", guard < 200, 1'b1);
      ack_m = 1'b0;
      tick();
   endtask

   initial begin
      respPulses       = 0;
      nonzeroWriteResp = 0;
      reset            = 1'b1;
      applyStimulus(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 32'h0);
      repeat (2) tick();
      checkVal("rst_in_ready", in_ready, 1'b1);
      checkVal("rst_req_m", req_m, 1'b0);
      checkVal("rst_count", count, 3'd0);
      checkVal("rst_resp_valid", resp_valid, 1'b0);
      checkVal("rst_addr_m", addr_m, 16'h0);
      reset = 1'b0;
      tick();

      // Single read.
      applyStimulus(1'b1, 1'b0, 16'h0010, 32'h1234, 1'b0, 32'h0);
      tick();
      in_valid = 1'b0;
      tick();
      checkVal("read_req_m", req_m, 1'b1);
      checkVal("read_addr_m", addr_m, 16'h0010);
      ack_m   = 1'b1;
      rdata_m = 32'hDEADBEEF;
      tick();
      ack_m = 1'b0;
      checkVal("read_resp_valid", resp_valid, 1'b1);
      checkVal("read_resp_cmd", resp_cmd, 1'b0);
      checkVal("read_resp_rdata", resp_rdata, 32'hDEADBEEF);
      checkVal("read_count", count, 3'd0);
      tick();
      checkVal("read_pulse_once", resp_valid, 1'b0);
      drain();

      // Fill with five back-to-back writes while no ack is given.
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b1, 1'b1, 16'h0100 + 16'(k), 32'(k), 1'b0, 32'h0);
         tick();
      end
      in_valid = 1'b0;
      checkVal("fill_count", count, 3'd4);
      checkVal("fill_in_ready", in_ready, 1'b0);
      ack_m = 1'b1;
      tick();
      ack_m = 1'b0;
      checkVal("fill_pop_count", count, 3'd3);
      checkVal("fill_pop_in_ready", in_ready, 1'b1);
      drain();

      // Ordering across pointer wrap with every request acked.
      addrLog.delete();
      respPulses       = 0;
      nonzeroWriteResp = 0;
      ack_m            = 1'b1;
      for (int a = 1; a <= 6; a++) pushOne(1'b1, 16'(a), $urandom);
      drain();
      checkVal("wrap_req_count", addrLog.size(), 6);
      for (int i = 0; i < 6 && i < addrLog.size(); i++)
         checkVal("wrap_addr_order", addrLog[i], 16'(i + 1));
      checkVal("wrap_resp_pulses", respPulses, 6);
      checkVal("wrap_write_rdata_zero", nonzeroWriteResp, 0);

      // Spurious ack with an empty queue.
      respPulses = 0;
      ack_m      = 1'b1;
      rdata_m    = 32'hCAFEF00D;
      tick();
      ack_m = 1'b0;
      tick();
      checkVal("spurious_count", count, 3'd0);
      checkVal("spurious_req_m", req_m, 1'b0);
      checkVal("spurious_no_resp", respPulses, 0);

      // Push and pop on the same edge.
      applyStimulus(1'b1, 1'b1, 16'h0021, 32'h21, 1'b0, 32'h0);
      tick();
      in_addr = 16'h0022;
      tick();
      checkVal("simul_pre_count", count, 3'd2);
      checkVal("simul_pre_addr", addr_m, 16'h0021);
      in_addr = 16'h0023;
      ack_m   = 1'b1;
      tick();
      in_valid = 1'b0;
      ack_m    = 1'b0;
      checkVal("simul_count", count, 3'd2);
      tick();
      checkVal("simul_next_req", req_m, 1'b1);
      checkVal("simul_next_addr", addr_m, 16'h0022);
      drain();

      // Reset during an outstanding request.
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 16'h0031 + 16'(k), 32'h0, 1'b0, 32'h0);
         tick();
      end
      in_valid = 1'b0;
      checkVal("midrst_pre_count", count, 3'd3);
      checkVal("midrst_pre_req", req_m, 1'b1);
      reset = 1'b1;
      #1;
      checkVal("midrst_req_m", req_m, 1'b0);
      checkVal("midrst_count", count, 3'd0);
      checkVal("midrst_in_ready", in_ready, 1'b1);
      tick();
      tick();
      reset      = 1'b0;
      respPulses = 0;
      repeat (6) tick();
      checkVal("midrst_no_resp", respPulses, 0);
      checkVal("midrst_post_count", count, 3'd0);

      // Randomized traffic, including acks outside of REQ.
      for (int n = 0; n < 400; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                       $urandom, ($urandom_range(0, 2) != 0), $urandom);
         tick();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
